// File: rtl/vga_timing.sv
// vga_timing: raster timing generator for a VGA-style display.
//
// Two counters (horizontal pixel, vertical line) advance on each rising
// edge of i_clk where i_ce is high. Every output is registered and decoded
// from the same next-count value that is loaded into the counters, so
// o_x/o_y and the blank/sync/strobe outputs always describe the same
// pixel with no skew between them.
//
// Ports
//   i_clk         : clock, all logic on the rising edge
//   i_rst         : synchronous active-high reset (overrides i_ce)
//   i_ce          : pixel-rate clock enable
//   o_hsync       : horizontal sync, H_SYNC_POL while active
//   o_vsync       : vertical sync, V_SYNC_POL while active
//   o_hblank      : high when hcount >= H_VISIBLE
//   o_vblank      : high when vcount >= V_VISIBLE
//   o_de          : display enable, ~o_hblank & ~o_vblank
//   o_x, o_y      : current horizontal / vertical count
//   o_line_start  : one-cycle strobe when the counts advance to hcount = 0
//   o_frame_start : one-cycle strobe when the counts advance to (0,0)
module vga_timing #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int CNT_W      = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ce,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_hblank,
    output logic             o_vblank,
    output logic             o_de,
    output logic [CNT_W-1:0] o_x,
    output logic [CNT_W-1:0] o_y,
    output logic             o_line_start,
    output logic             o_frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_VISIBLE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
        V_VISIBLE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0 ||
        CNT_W == 0) begin : g_bad_zero
        $error("vga_timing: timing parameters and CNT_W must be non-zero");
    end

    if (longint'(H_TOTAL) > (longint'(1) << CNT_W) ||
        longint'(V_TOTAL) > (longint'(1) << CNT_W)) begin : g_bad_width
        $error("vga_timing: H_TOTAL or V_TOTAL does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [CNT_W-1:0] h_d, h_q;
    logic [CNT_W-1:0] v_d, v_q;
    logic             hsync_d, hsync_q;
    logic             vsync_d, vsync_q;
    logic             hblank_d, hblank_q;
    logic             vblank_d, vblank_q;
    logic             de_d, de_q;
    logic             line_start_d, line_start_q;
    logic             frame_start_d, frame_start_q;

    always_comb begin
        h_d           = h_q;
        v_d           = v_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (i_ce) begin
            if (h_q == H_LAST) begin
                h_d          = '0;
                line_start_d = 1'b1;
                if (v_q == V_LAST) begin
                    v_d           = '0;
                    frame_start_d = 1'b1;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end

        // Levels are decoded from the next counts so they land in the
        // same cycle as the counter values they describe. With i_ce low
        // the next counts equal the current ones, so the levels hold.
        hblank_d = (h_d >= H_VIS_END);
        vblank_d = (v_d >= V_VIS_END);
        de_d     = ~hblank_d & ~vblank_d;
        hsync_d  = ((h_d >= H_SYNC_BEG) && (h_d < H_SYNC_END)) ? H_SYNC_POL : ~H_SYNC_POL;
        // v_d only moves on the horizontal wrap, so vsync can only change
        // in the cycle in which hcount becomes 0.
        vsync_d  = ((v_d >= V_SYNC_BEG) && (v_d < V_SYNC_END)) ? V_SYNC_POL : ~V_SYNC_POL;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_q           <= '0;
            v_q           <= '0;
            hblank_q      <= 1'b0;
            vblank_q      <= 1'b0;
            de_q          <= 1'b1;
            hsync_q       <= ~H_SYNC_POL;
            vsync_q       <= ~V_SYNC_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign o_x           = h_q;
    assign o_y           = v_q;
    assign o_hblank      = hblank_q;
    assign o_vblank      = vblank_q;
    assign o_de          = de_q;
    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_line_start  = line_start_q;
    assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing with a small 8x6 raster (H 4/1/2/1, V 3/1/1/1).
// Two instances run side by side on identical stimulus: one with
// active-low syncs, one with active-high syncs.
module tb_vga_timing;

    localparam int CW = 4;
    localparam int HT = 8;
    localparam int VT = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce  = 1'b0;

    logic          hs0, vs0, hb0, vb0, de0, ls0, fs0;
    logic [CW-1:0] x0, y0;
    logic          hs1, vs1, hb1, vb1, de1, ls1, fs1;
    logic [CW-1:0] x1, y1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: number of enabled pixels since the last frame
    // boundary; x and y follow directly from it.
    int  tick   = 0;
    bit  exp_ls = 1'b0;
    bit  exp_fs = 1'b0;
    int  fs_cnt = 0;

    always #5 clk = ~clk;

    vga_timing #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .CNT_W(CW)
    ) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_ce(ce),
        .o_hsync(hs0), .o_vsync(vs0), .o_hblank(hb0), .o_vblank(vb0),
        .o_de(de0), .o_x(x0), .o_y(y0),
        .o_line_start(ls0), .o_frame_start(fs0)
    );

    vga_timing #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CNT_W(CW)
    ) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_ce(ce),
        .o_hsync(hs1), .o_vsync(vs1), .o_hblank(hb1), .o_vblank(vb1),
        .o_de(de1), .o_x(x1), .o_y(y1),
        .o_line_start(ls1), .o_frame_start(fs1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (x=%0d y=%0d t=%0t)",
                   tag, obs, expv, tick % HT, tick / HT, $time);
        end
    endtask

    task automatic check_all();
        int  ex, ey;
        bit  hsa, vsa, hbx, vbx;
        ex  = tick % HT;
        ey  = tick / HT;
        hbx = (ex >= 4);
        vbx = (ey >= 3);
        hsa = (ex >= 5) && (ex < 7);
        vsa = (ey == 4);
        check("x0",      32'(x0),  32'(ex));
        check("y0",      32'(y0),  32'(ey));
        check("hblank0", 32'(hb0), 32'(hbx));
        check("vblank0", 32'(vb0), 32'(vbx));
        check("de0",     32'(de0), 32'(!hbx && !vbx));
        check("hsync0",  32'(hs0), 32'(!hsa));
        check("vsync0",  32'(vs0), 32'(!vsa));
        check("lstart0", 32'(ls0), 32'(exp_ls));
        check("fstart0", 32'(fs0), 32'(exp_fs));
        check("x1",      32'(x1),  32'(ex));
        check("y1",      32'(y1),  32'(ey));
        check("de1",     32'(de1), 32'(!hbx && !vbx));
        check("hblank1", 32'(hb1), 32'(hbx));
        check("vblank1", 32'(vb1), 32'(vbx));
        check("hsync1",  32'(hs1), 32'(hsa));
        check("vsync1",  32'(vs1), 32'(vsa));
        check("lstart1", 32'(ls1), 32'(exp_ls));
        check("fstart1", 32'(fs1), 32'(exp_fs));
    endtask

    // Drive one clock with the given inputs, advance the model and compare.
    task automatic step(input bit ce_v, input bit rst_v);
        ce  = ce_v;
        rst = rst_v;
        @(posedge clk);
        if (rst_v) begin
            tick   = 0;
            exp_ls = 1'b0;
            exp_fs = 1'b0;
        end else if (ce_v) begin
            tick   = (tick + 1) % (HT * VT);
            exp_ls = (tick % HT) == 0;
            exp_fs = (tick == 0);
        end else begin
            exp_ls = 1'b0;
            exp_fs = 1'b0;
        end
        #1;
        if (fs0) fs_cnt++;
        check_all();
    endtask

    initial begin
        // Reset, with i_ce high on one of the cycles to show reset wins.
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);

        // One full line.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
        check("line_wrap_x",  32'(x0),  32'd0);
        check("line_wrap_ls", 32'(ls0), 32'd1);

        // Rest of the frame: exactly one frame_start, on cycle 48.
        fs_cnt = 0;
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0);
        check("frame_fs_at48", 32'(fs0), 32'd1);
        check("frame_fs_once", 32'(fs_cnt), 32'd1);

        // Half-rate enable: a full frame in 96 clocks.
        fs_cnt = 0;
        for (int i = 0; i < 48; i++) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
        end
        check("half_rate_fs_once", 32'(fs_cnt), 32'd1);
        check("half_rate_x", 32'(x0), 32'd0);
        check("half_rate_y", 32'(y0), 32'd0);

        // Run to (6,4), then abort the frame with a reset pulse.
        for (int i = 0; i < 38; i++) step(1'b1, 1'b0);
        check("pre_rst_x", 32'(x0), 32'd6);
        check("pre_rst_y", 32'(y0), 32'd4);
        step(1'b1, 1'b1);
        check("rst_hsync", 32'(hs0), 32'd1);
        check("rst_vsync", 32'(vs0), 32'd1);
        check("rst_fs",    32'(fs0), 32'd0);
        // First enable after release goes to (1,0) with no strobe.
        step(1'b1, 1'b0);
        check("post_rst_x",  32'(x0),  32'd1);
        check("post_rst_ls", 32'(ls0), 32'd0);

        // Random enable pattern with occasional resets.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 59) == 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 The module SHALL have parameter H_VISIBLE, default 640, meaning active pixels per line.
REQ-002 The module SHALL have parameter H_FRONT, default 16, meaning horizontal front porch in pixels.
REQ-003 The module SHALL have parameter H_SYNC, default 96, meaning horizontal sync width in pixels.
REQ-004 The module SHALL have parameter H_BACK, default 48, meaning horizontal back porch in pixels.
REQ-005 The module SHALL have parameters V_VISIBLE, V_FRONT, V_SYNC and V_BACK, defaults 480, 10, 2 and 33, with the same meanings in lines.
REQ-006 The module SHALL have parameters H_SYNC_POL and V_SYNC_POL, default 0 each, meaning the active sync level.
REQ-007 The module SHALL have parameter CNT_W, default 10, meaning the counter and coordinate width.
REQ-008 The module SHALL have port i_clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-009 The module SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-010 The module SHALL have port i_ce, input, 1 bit: pixel-rate clock enable.
REQ-011 The module SHALL have ports o_hsync and o_vsync, outputs, 1 bit each: sync pulses at the configured polarity.
REQ-012 The module SHALL have ports o_hblank and o_vblank, outputs, 1 bit each: high outside the visible region.
REQ-013 The module SHALL have port o_de, output, 1 bit: display enable, equal to ~o_hblank & ~o_vblank.
REQ-014 The module SHALL have ports o_x and o_y, outputs, CNT_W bits each: current horizontal and vertical counter values.
REQ-015 The module SHALL have ports o_line_start and o_frame_start, outputs, 1 bit each: single-cycle strobes.

Function
REQ-016 The module SHALL define H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK and V_TOTAL analogously; elaboration SHALL fail if either total exceeds 2^CNT_W or any parameter is 0.
REQ-017 On a rising edge with i_ce=1, the horizontal count SHALL increment, wrapping from H_TOTAL-1 to 0.
REQ-018 On the horizontal wrap, the vertical count SHALL increment, wrapping from V_TOTAL-1 to 0; otherwise it SHALL hold.
REQ-019 With i_ce=0, both counts and all level outputs SHALL hold, and both strobes SHALL be 0.
REQ-020 All outputs SHALL be registered and SHALL reflect the count pair held in the same cycle, with zero cycles of skew between o_x/o_y and the decoded outputs.
REQ-021 o_hblank SHALL be 1 iff hcount >= H_VISIBLE; o_vblank SHALL be 1 iff vcount >= V_VISIBLE.
REQ-022 o_hsync SHALL equal H_SYNC_POL iff H_VISIBLE+H_FRONT <= hcount < H_VISIBLE+H_FRONT+H_SYNC, and ~H_SYNC_POL otherwise.
REQ-023 o_vsync SHALL follow the same rule on vcount using the V_* parameters and V_SYNC_POL; it SHALL change only in the cycle in which hcount becomes 0.
REQ-024 o_line_start SHALL be 1 for exactly the one i_clk cycle in which the counts advance to hcount=0.
REQ-025 o_frame_start SHALL be 1 for exactly the one i_clk cycle in which the counts advance to (0,0), coincident with o_line_start.
REQ-026 The counts SHALL never take values at or above H_TOTAL or V_TOTAL.

Reset
REQ-027 While i_rst=1 at a rising edge, the module SHALL set both counts to 0, o_x=0, o_y=0, o_hblank=0, o_vblank=0, o_de=1, o_hsync=~H_SYNC_POL, o_vsync=~V_SYNC_POL and both strobes to 0, regardless of i_ce.
REQ-028 Reset asserted mid-line or mid-frame SHALL abort the frame; the first i_ce after release SHALL advance the counts to (1,0) with no strobe.

Verification (H 4/1/2/1, V 3/1/1/1, polarities 0, CNT_W=4)
REQ-029 Bench: reset, then i_ce=1 for 8 cycles -> o_x sequence 0..7,0; o_hblank=1 at x=4..7; o_hsync=0 at x=5,6 only; o_line_start on return to x=0.
REQ-030 Bench: i_ce=1 for 48 cycles -> o_y steps 0..5 then 0; o_vblank=1 at y=3..5; o_vsync=0 at y=4 only; one o_frame_start at cycle 48.
REQ-031 Bench: i_ce toggling 1,0 -> counts and levels hold during i_ce=0 cycles; a full frame takes 96 clocks; strobes are never high while i_ce=0.
REQ-032 Bench: i_rst pulse at (6,4) -> next cycle (0,0), o_hsync=1, o_vsync=1, o_de=1, no o_frame_start.
REQ-033 Bench: H_SYNC_POL=1, V_SYNC_POL=1 -> o_hsync=1 at x=5,6, o_vsync=1 at y=4, low elsewhere and after reset.
